// File: rtl/trace_arbiter.sv
// Trace arbiter: per-source capture FIFOs drained round-robin into one
// registered trace-buffer write port, with sticky overflow flags and drop count.
module trace_arbiter #(
  parameter  int N         = 5,
  parameter  int Fpay      = 32,
  parameter  int SRC_DEPTH = 4,
  localparam int SIDw      = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*Fpay-1:0] din_all,
  input  logic [N-1:0]      wr_all,
  input  logic [N-1:0]      ip_select,
  input  logic              tb_full,
  input  logic              clr_ovf,
  output logic [Fpay-1:0]   dout,
  output logic [SIDw-1:0]   src_id,
  output logic              wr_en,
  output logic [N-1:0]      ovf_flags,
  output logic [15:0]       drop_cnt
);
  localparam int AW = $clog2(SRC_DEPTH);
  localparam int CW = AW + 1;

  logic [Fpay-1:0] mem    [N][SRC_DEPTH];
  logic [AW-1:0]   rd_ptr [N];
  logic [AW-1:0]   wr_ptr [N];
  logic [CW-1:0]   cnt    [N];
  logic [SIDw-1:0] last_grant;

  logic [N-1:0]    not_empty, full, pop, push, drop;
  logic            gnt_valid;
  logic [SIDw-1:0] gnt_idx, cand;
  logic [16:0]     drop_sum, dcnt_next;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      not_empty[i] = (cnt[i] != '0);
      full[i]      = (cnt[i] == CW'(SRC_DEPTH));
    end
  end

  // Round-robin search from last_grant+1; first non-empty source wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last_grant;
    cand      = '0;
    if (!tb_full) begin
      for (int unsigned off = 1; off <= N; off++) begin
        cand = SIDw'((32'(last_grant) + off) % N);
        if (!gnt_valid && not_empty[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  // A full FIFO still accepts a word when it is popped on the same edge.
  always_comb begin
    drop_sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop[i]   = gnt_valid && (gnt_idx == SIDw'(i));
      push[i]  = wr_all[i] && ip_select[i] && (!full[i] || pop[i]);
      drop[i]  = wr_all[i] && ip_select[i] && full[i] && !pop[i];
      drop_sum = drop_sum + 17'(drop[i]);
    end
    dcnt_next = clr_ovf ? drop_sum : (17'(drop_cnt) + drop_sum);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= din_all[i*Fpay +: Fpay];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      src_id     <= '0;
      wr_en      <= 1'b0;
      last_grant <= SIDw'(N - 1);
      ovf_flags  <= '0;
      drop_cnt   <= '0;
    end else begin
      wr_en <= gnt_valid;
      if (gnt_valid) begin
        dout       <= mem[gnt_idx][rd_ptr[gnt_idx]];
        src_id     <= gnt_idx;
        last_grant <= gnt_idx;
      end
      ovf_flags <= clr_ovf ? drop : (ovf_flags | drop);
      drop_cnt  <= (dcnt_next > 17'h0FFFF) ? 16'hFFFF : dcnt_next[15:0];
    end
  end
endmodule

// File: tb/tb_trace_arbiter.sv
// Self-checking bench for trace_arbiter: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_trace_arbiter;
  localparam int N  = 5;
  localparam int FP = 32;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N*FP-1:0] din_all = '0;
  logic [N-1:0]    wr_all = '0;
  logic [N-1:0]    ip_select = '0;
  logic            tb_full = 1'b0;
  logic            clr_ovf = 1'b0;
  logic [FP-1:0]   dout;
  logic [2:0]      src_id;
  logic            wr_en;
  logic [N-1:0]    ovf_flags;
  logic [15:0]     drop_cnt;

  always #5 clk = ~clk;

  trace_arbiter #(.N(N), .Fpay(FP), .SRC_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .din_all(din_all), .wr_all(wr_all),
    .ip_select(ip_select), .tb_full(tb_full), .clr_ovf(clr_ovf),
    .dout(dout), .src_id(src_id), .wr_en(wr_en),
    .ovf_flags(ovf_flags), .drop_cnt(drop_cnt)
  );

  // Reference model state
  logic [FP-1:0] q [N][$];
  int            m_last;
  logic          m_wr;
  logic [FP-1:0] m_dout;
  int            m_src;
  logic [N-1:0]  m_ovf;
  int            m_drop;

  int n_pass = 0;
  int n_chk  = 0;

  logic [N*FP-1:0] din;
  logic [N-1:0]    r_wr, r_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wr_en"},     32'(wr_en),     32'(m_wr));
    chk({tag, ".dout"},      dout,           m_dout);
    chk({tag, ".src_id"},    32'(src_id),    m_src);
    chk({tag, ".ovf_flags"}, 32'(ovf_flags), 32'(m_ovf));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  m_drop);
  endtask

  // One clock edge of the specified behaviour, using the inputs held at that edge.
  task automatic model_edge();
    int k, idx, drops;
    logic [N-1:0] dv;
    k = -1;
    if (!tb_full)
      for (int off = 1; off <= N; off++) begin
        idx = (m_last + off) % N;
        if (k < 0 && q[idx].size() > 0) k = idx;
      end
    if (k >= 0) begin
      m_dout = q[k].pop_front();
      m_src  = k;
      m_last = k;
      m_wr   = 1'b1;
    end else m_wr = 1'b0;
    drops = 0;
    dv = '0;
    for (int i = 0; i < N; i++)
      if (wr_all[i] && ip_select[i]) begin
        if (q[i].size() < D) q[i].push_back(din_all[i*FP +: FP]);
        else begin
          drops++;
          dv[i] = 1'b1;
        end
      end
    m_ovf  = clr_ovf ? dv : (m_ovf | dv);
    m_drop = clr_ovf ? drops : (m_drop + drops);
    if (m_drop > 65535) m_drop = 65535;
  endtask

  task automatic cycle(input logic [N*FP-1:0] d, input logic [N-1:0] wr,
                       input logic [N-1:0] sel, input logic tbf, input logic clr,
                       input string tag);
    din_all = d; wr_all = wr; ip_select = sel; tb_full = tbf; clr_ovf = clr;
    @(posedge clk); #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    wr_all = '0; clr_ovf = 1'b0; tb_full = 1'b0;
    #2;
    for (int i = 0; i < N; i++) q[i].delete();
    m_last = N - 1; m_wr = 1'b0; m_dout = '0; m_src = 0; m_ovf = '0; m_drop = 0;
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    do_reset("reset0");

    // Single capture, two-edge latency
    din = '0; din[2*FP +: FP] = 32'hA5A5_0002;
    cycle(din, 5'b00100, '1, 1'b0, 1'b0, "single_e0");
    chk("single_e0_wr", 32'(wr_en), 32'd0);
    cycle('0, '0, '1, 1'b0, 1'b0, "single_e1");
    chk("single_e1_wr", 32'(wr_en), 32'd1);
    chk("single_e1_dout", dout, 32'hA5A5_0002);
    chk("single_e1_src", 32'(src_id), 32'd2);
    cycle('0, '0, '1, 1'b0, 1'b0, "single_e2");
    chk("single_e2_wr", 32'(wr_en), 32'd0);

    // Fairness after reset: order 0..4
    do_reset("reset1");
    for (int i = 0; i < N; i++) din[i*FP +: FP] = i;
    cycle(din, 5'b11111, '1, 1'b0, 1'b0, "fair_load");
    for (int k = 0; k < N; k++) begin
      cycle('0, '0, '1, 1'b0, 1'b0, "fair");
      chk("fair_wr", 32'(wr_en), 32'd1);
      chk("fair_src", 32'(src_id), k);
    end
    chk("fair_drop", 32'(drop_cnt), 32'd0);

    // Overflow on source 1 while blocked
    do_reset("reset2");
    for (int v = 1; v <= 6; v++) begin
      din = '0; din[1*FP +: FP] = v;
      cycle(din, 5'b00010, '1, 1'b1, 1'b0, "ovf_fill");
    end
    chk("ovf_flags", 32'(ovf_flags), 32'h02);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    for (int v = 1; v <= 4; v++) begin
      cycle('0, '0, '1, 1'b0, 1'b0, "ovf_drain");
      chk("ovf_drain_dout", dout, v);
    end

    // Clear colliding with a drop on source 4
    for (int v = 0; v < 4; v++) begin
      din = '0; din[4*FP +: FP] = 32'h4000 + v;
      cycle(din, 5'b10000, '1, 1'b1, 1'b0, "clr_fill");
    end
    cycle(din, 5'b10000, '1, 1'b1, 1'b1, "clr_hit");
    chk("clr_flags", 32'(ovf_flags), 32'h10);
    chk("clr_drop", 32'(drop_cnt), 32'd1);
    for (int v = 0; v < 4; v++) cycle('0, '0, '1, 1'b0, 1'b0, "clr_drain");

    // Backpressure toggling under continuous source-3 traffic
    for (int c = 0; c < 16; c++) begin
      din = '0; din[3*FP +: FP] = 32'h300 + c;
      cycle(din, 5'b01000, '1, 1'(c % 2 == 0), 1'b0, "bp");
      if (tb_full) chk("bp_no_wr", 32'(wr_en), 32'd0);
    end
    for (int c = 0; c < 6; c++) cycle('0, '0, '1, 1'b0, 1'b0, "bp_drain");

    // Mid-operation reset with three words buffered
    for (int v = 0; v < 3; v++) begin
      din = '0; din[0 +: FP] = 32'hBEEF_0000 + v;
      cycle(din, 5'b00001, '1, 1'b1, 1'b0, "mid_fill");
    end
    do_reset("mid_reset");
    chk("mid_dout", dout, 32'd0);
    chk("mid_wr", 32'(wr_en), 32'd0);
    for (int c = 0; c < 6; c++) begin
      cycle('0, '0, '1, 1'b0, 1'b0, "mid_idle");
      chk("mid_no_stale", 32'(wr_en), 32'd0);
    end

    // Random traffic, including ip_select changes and clears
    r_sel = '1;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) din[i*FP +: FP] = $urandom;
      r_wr = N'($urandom);
      if ($urandom_range(0, 7) == 0) r_sel = N'($urandom);
      cycle(din, r_wr, r_sel, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 19) == 0), "rand");
    end

    // drop_cnt saturation
    do_reset("reset3");
    for (int c = 0; c < 13120; c++) cycle(din, '1, '1, 1'b1, 1'b0, "sat");
    chk("sat_drop", 32'(drop_cnt), 32'h0000_FFFF);
    cycle(din, '0, '1, 1'b1, 1'b1, "sat_clr");
    chk("sat_clr_drop", 32'(drop_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/trace_arbiter.md
TRACE_ARBITER -- requirements
Module: trace_arbiter

Interface
REQ-001 SHALL have parameter N, default 5, number of trace sources (four tiles plus NoC).
REQ-002 SHALL have parameter Fpay, default 32, trace word width.
REQ-003 SHALL have parameter SRC_DEPTH, default 4, per-source FIFO depth; power of two, at least 2.
REQ-004 SHALL have local parameter SIDw = ceil(log2(N)), source-ID width (3 at default).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port din_all, input, N*Fpay bits: source i word at [(i+1)*Fpay-1 : i*Fpay].
REQ-008 SHALL have port wr_all, input, N bits: per-source trace trigger/write strobe.
REQ-009 SHALL have port ip_select, input, N bits: per-source capture enable mask.
REQ-010 SHALL have port tb_full, input, 1 bit: downstream trace buffer cannot accept a word.
REQ-011 SHALL have port clr_ovf, input, 1 bit: single-cycle clear of overflow status.
REQ-012 SHALL have port dout, output, Fpay bits: registered word to the trace buffer.
REQ-013 SHALL have port src_id, output, SIDw bits: index of the source that produced dout.
REQ-014 SHALL have port wr_en, output, 1 bit: registered write strobe to the trace buffer.
REQ-015 SHALL have port ovf_flags, output, N bits: sticky per-source overflow flags.
REQ-016 SHALL have port drop_cnt, output, 16 bits: saturating count of dropped words.

Function
REQ-017 SHALL capture din_i into source FIFO i on every edge where wr_all[i]=1 and ip_select[i]=1; otherwise wr_all[i] is ignored.
REQ-018 SHALL NOT capture on a full FIFO unless that FIFO is popped in the same cycle; in that case the push SHALL succeed.
REQ-019 SHALL, on a push to a full FIFO that is not popped that cycle, drop the word, set ovf_flags[i], and increment drop_cnt by 1 per dropped word, saturating at 16'hFFFF.
REQ-020 SHALL increment drop_cnt by the number of sources dropping in the same cycle (0..N), saturating.
REQ-021 SHALL clear ovf_flags and drop_cnt on clr_ovf=1; a drop in that same cycle SHALL win (flag set, drop_cnt equals the drops that cycle).
REQ-022 SHALL grant round-robin among non-empty FIFOs when tb_full=0: search starts at last_grant+1 modulo N; at most one pop per cycle.
REQ-023 SHALL initialise last_grant to N-1 on reset, so source 0 has first priority.
REQ-024 SHALL, on a grant to source k, register dout=head of FIFO k, src_id=k, wr_en=1 on the same edge as the pop, and set last_grant=k.
REQ-025 SHALL drive wr_en=0 on any edge with tb_full=1 or all FIFOs empty, pop nothing, and leave last_grant, dout and src_id unchanged.
REQ-026 SHALL have latency 2 edges: a word sampled at edge t into an empty, uncontended system appears with wr_en=1 after edge t+1.
REQ-027 SHALL sustain one output word per cycle while any FIFO is non-empty and tb_full=0.
REQ-028 SHALL preserve per-source word order and never duplicate a word.
REQ-029 SHALL still drain already-buffered words after ip_select[i] is cleared.

Reset
REQ-030 SHALL, while reset=1, asynchronously force: all FIFOs empty, wr_en=0, dout=0, src_id=0, ovf_flags=0, drop_cnt=0, last_grant=N-1.
REQ-031 SHALL discard words buffered at a mid-operation reset; the first post-reset capture SHALL be the first edge with reset=0.

Verification
REQ-032 SHALL verify single capture: wr_all=5'b00100, din_2=32'hA5A5_0002 at edge 0, tb_full=0 -> after edge 1: wr_en=1, dout=32'hA5A5_0002, src_id=2; after edge 2: wr_en=0.
REQ-033 SHALL verify fairness: wr_all=5'b11111 for one cycle, din_i=i -> five consecutive wr_en cycles, src_id order 0,1,2,3,4, drop_cnt=0.
REQ-034 SHALL verify overflow: tb_full=1, wr_all[1]=1 for 6 cycles with din=1..6 -> ovf_flags=5'b00010, drop_cnt=2; after tb_full=0 -> dout 1,2,3,4 in order.
REQ-035 SHALL verify backpressure: tb_full toggling 1/0 each cycle under continuous wr_all[3] traffic -> wr_en never high on an edge with tb_full=1, no loss until FIFO full.
REQ-036 SHALL verify clear/drop collision: clr_ovf=1 in the same cycle as one drop on source 4 -> ovf_flags=5'b10000, drop_cnt=1.
REQ-037 SHALL verify mid-operation reset: reset pulsed with 3 words buffered -> all outputs zero immediately, no stale word is emitted afterwards.
